// File: rtl/vslide_pkg.sv
// vslide_pkg: shared types and default dimensions for the vslide_seq sequencer
// and its vector_slide datapath.
package vslide_pkg;

  // Default dimensions; the request struct below is sized from these.
  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_VECTOR_LANES = 16;
  localparam int DEF_ADDR_WIDTH   = 5;
  localparam int DEF_MAX_GROUP    = 8;
  localparam int DEF_SHIFT_WIDTH  = $clog2(DEF_VECTOR_LANES);
  localparam int DEF_COUNT_WIDTH  = $clog2(DEF_MAX_GROUP);
  localparam int VLEN_BITS        = DEF_VECTOR_LANES * DEF_DATA_WIDTH;

  // Sequencer states, one per pipeline step of a single register.
  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_B,
    EXEC,
    WB
  } state_t;

  // A latched slide-up request.
  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0]  vd;
    logic [DEF_ADDR_WIDTH-1:0]  vs1;
    logic [DEF_ADDR_WIDTH-1:0]  vs2;
    logic [DEF_SHIFT_WIDTH-1:0] shift;
    logic [DEF_COUNT_WIDTH-1:0] count;
  } req_t;

  // Register index of element idx of a group; wraps modulo the register file size.
  function automatic logic [DEF_ADDR_WIDTH-1:0] grp_addr(
    input logic [DEF_ADDR_WIDTH-1:0]  base,
    input logic [DEF_COUNT_WIDTH-1:0] idx
  );
    return base + DEF_ADDR_WIDTH'(idx);
  endfunction

endpackage

// File: rtl/vector_slide.sv
// vector_slide: combinational slide-up. Result lane i takes vec_a lane (i-shift)
// when i >= shift, otherwise vec_b lane i.
module vector_slide #(
  parameter int DATA_WIDTH   = 32,
  parameter int VECTOR_LANES = 16
) (
  input  logic [VECTOR_LANES*DATA_WIDTH-1:0] vec_a,
  input  logic [VECTOR_LANES*DATA_WIDTH-1:0] vec_b,
  input  logic [$clog2(VECTOR_LANES)-1:0]    shift,
  output logic [VECTOR_LANES*DATA_WIDTH-1:0] result
);

  localparam int SW = $clog2(VECTOR_LANES);

  logic [DATA_WIDTH-1:0] a_lane   [VECTOR_LANES];
  logic [DATA_WIDTH-1:0] b_lane   [VECTOR_LANES];
  logic [DATA_WIDTH-1:0] res_lane [VECTOR_LANES];

  // View the flat vectors as lane arrays and repack the result.
  for (genvar g = 0; g < VECTOR_LANES; g++) begin : g_lane
    assign a_lane[g] = vec_a[g*DATA_WIDTH +: DATA_WIDTH];
    assign b_lane[g] = vec_b[g*DATA_WIDTH +: DATA_WIDTH];
    assign result[g*DATA_WIDTH +: DATA_WIDTH] = res_lane[g];
  end

  // Per-lane select between the shifted source and the fill operand.
  always_comb begin
    for (int i = 0; i < VECTOR_LANES; i++) begin
      // NOTE: every lane gets a default before the conditional override so no latch is inferred.
      res_lane[i] = b_lane[i];
      if (SW'(i) >= shift) begin
        res_lane[i] = a_lane[SW'(i) - shift];
      end
    end
  end

endmodule

// File: rtl/vslide_seq.sv
// vslide_seq: sequences a slide-up over a register group of 1..MAX_GROUP vector
// registers, reading source and fill operands through one register-file read
// port, sliding them in vector_slide and writing each result back in order.
// Optional feature macro VSLIDE_SEQ_SKIPFILL_EN: with a zero shift the fill read
// is skipped and each register takes 3 cycles instead of 4.
module vslide_seq
  import vslide_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int VECTOR_LANES = DEF_VECTOR_LANES,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int MAX_GROUP    = DEF_MAX_GROUP
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic [ADDR_WIDTH-1:0]              req_vd,
  input  logic [ADDR_WIDTH-1:0]              req_vs1,
  input  logic [ADDR_WIDTH-1:0]              req_vs2,
  input  logic [$clog2(VECTOR_LANES)-1:0]    req_shift,
  input  logic [$clog2(MAX_GROUP)-1:0]       req_count,
  output logic                               rf_ren,
  output logic [ADDR_WIDTH-1:0]              rf_raddr,
  input  logic [VECTOR_LANES*DATA_WIDTH-1:0] rf_rdata,
  output logic                               rf_we,
  output logic [ADDR_WIDTH-1:0]              rf_waddr,
  output logic [VECTOR_LANES*DATA_WIDTH-1:0] rf_wdata,
  output logic                               busy,
  output logic                               done
);

  localparam int VLEN        = VECTOR_LANES * DATA_WIDTH;
  localparam int COUNT_WIDTH = $clog2(MAX_GROUP);

`ifdef VSLIDE_SEQ_SKIPFILL_EN
  localparam bit SKIP_FILL = 1'b1;
`else
  localparam bit SKIP_FILL = 1'b0;
`endif

  state_t                 state;
  req_t                   req_q;
  logic [COUNT_WIDTH-1:0] k;
  logic [VLEN-1:0]        a_reg;
  logic [VLEN-1:0]        b_reg;
  logic                   last_reg;
  logic                   skip_b;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign last_reg  = (k == req_q.count);
  // A zero shift never selects the fill operand, so its read can be dropped.
  assign skip_b    = SKIP_FILL && (req_q.shift == '0);

  // Write data is the slide of the operand registers; it is sampled during WB.
  vector_slide #(
    .DATA_WIDTH   (DATA_WIDTH),
    .VECTOR_LANES (VECTOR_LANES)
  ) u_slide (
    .vec_a  (a_reg),
    .vec_b  (b_reg),
    .shift  (req_q.shift),
    .result (rf_wdata)
  );

  // Sequencer FSM with registered register-file controls, index counter and operand capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      req_q    <= '0;
      k        <= '0;
      // NOTE: operand registers are reset too so a reset leaves rf_wdata at zero.
      a_reg    <= '0;
      b_reg    <= '0;
      rf_ren   <= 1'b0;
      rf_raddr <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      done     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees pre-edge state.
      rf_ren <= 1'b0;
      rf_we  <= 1'b0;
      done   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            req_q    <= '{vd: req_vd, vs1: req_vs1, vs2: req_vs2,
                          shift: req_shift, count: req_count};
            k        <= '0;
            state    <= RD_A;
            rf_ren   <= 1'b1;
            rf_raddr <= req_vs1;
          end
        end
        RD_A: begin
          if (skip_b) begin
            state <= EXEC;
          end else begin
            state    <= RD_B;
            rf_ren   <= 1'b1;
            rf_raddr <= grp_addr(req_q.vs2, k);
          end
        end
        RD_B: begin
          a_reg <= rf_rdata;
          state <= EXEC;
        end
        EXEC: begin
          // With the fill read skipped, the data arriving now is the source operand.
          if (skip_b) a_reg <= rf_rdata;
          else        b_reg <= rf_rdata;
          state    <= WB;
          rf_we    <= 1'b1;
          rf_waddr <= grp_addr(req_q.vd, k);
          done     <= last_reg;
        end
        WB: begin
          if (last_reg) begin
            state <= IDLE;
          end else begin
            k        <= k + COUNT_WIDTH'(1);
            state    <= RD_A;
            rf_ren   <= 1'b1;
            rf_raddr <= grp_addr(req_q.vs1, k + COUNT_WIDTH'(1));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
